traffic_conflict_monitor: RTL

Safety stage placed directly downstream of the traffic-light controller: it consumes the controller's `nslight`/`ewlight` phase outputs and drives the physical lamp outputs. In normal operation it forwards the lights with one register stage. It checks every cycle for conflicting greens, illegal encodings, illegal phase sequences, and phase-duration violations. On any violation it latches a fault code and forces both directions into flashing red until a qualified clear.

---
 rtl/traffic_conflict_monitor_if.sv | 33 +++
 rtl/traffic_conflict_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor_if.sv
// Bundle between the traffic-light controller and the conflict monitor:
// controller phase requests plus the lamp drives and fault status coming back.
interface traffic_conflict_monitor_if;
    logic [2:0] nslight;
    logic [2:0] ewlight;
    logic       fault_clear;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic       fault;
    logic [2:0] fault_code;

    // Controller / test side: drives phases and the clear request.
    modport master (
        output nslight,
        output ewlight,
        output fault_clear,
        input  ns_lamp,
        input  ew_lamp,
        input  fault,
        input  fault_code
    );

    // Monitor side: observes phases, owns the lamps and fault status.
    modport slave (
        input  nslight,
        input  ewlight,
        input  fault_clear,
        output ns_lamp,
        output ew_lamp,
        output fault,
        output fault_code
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic-light controller and the lamps. Forwards
// the phases with one register stage, checks every cycle for conflicting
// greens, bad encodings, illegal sequences and phase-duration violations,
// and on the first violation latches a code and flashes red in both
// directions until a qualified clear.
module traffic_conflict_monitor #(
    parameter int MAX_GREEN  = 40,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_YELLOW = 10,
    parameter int FLASH_DIV  = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    traffic_conflict_monitor_if.slave     bus
);
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    localparam logic [CNT_W-1:0] MAX_GREEN_C  = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_YELLOW_C = CNT_W'(MAX_YELLOW);
    localparam logic [CNT_W-1:0] FLASH_END_C  = CNT_W'(FLASH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT_C    = {CNT_W{1'b1}};

    typedef enum logic {
        ST_MONITOR = 1'b0,
        ST_FAULT   = 1'b1
    } state_t;

    // Only the three one-hot phases are legal.
    function automatic logic enc_ok(input logic [2:0] l);
        return (l == LT_RED) || (l == LT_YEL) || (l == LT_GRN);
    endfunction

    // Hold, red->green, green->yellow, yellow->red are the only legal moves.
    function automatic logic seq_ok(input logic [2:0] prev, input logic [2:0] cur);
        return (cur == prev) ||
               ((prev == LT_RED) && (cur == LT_GRN)) ||
               ((prev == LT_GRN) && (cur == LT_YEL)) ||
               ((prev == LT_YEL) && (cur == LT_RED));
    endfunction

    // Saturating run counter: counts while active, clears otherwise.
    function automatic logic [CNT_W-1:0] run_next(input logic active, input logic [CNT_W-1:0] cnt);
        if (!active) begin
            return CNT_ZERO_C;
        end else if (cnt == CNT_SAT_C) begin
            return cnt;
        end else begin
            return cnt + CNT_ONE_C;
        end
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       ns_prev_q, ns_prev_d, ew_prev_q, ew_prev_d;
    logic [CNT_W-1:0] ns_gcnt_q, ns_gcnt_d, ns_ycnt_q, ns_ycnt_d;
    logic [CNT_W-1:0] ew_gcnt_q, ew_gcnt_d, ew_ycnt_q, ew_ycnt_d;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic             flash_red_q, flash_red_d;
    logic [2:0]       ns_lamp_q, ns_lamp_d, ew_lamp_q, ew_lamp_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;
    logic [2:0]       viol_code_s;
    logic [2:0]       ns_s, ew_s;

    assign ns_s = bus.nslight;
    assign ew_s = bus.ewlight;

    // Prioritised violation check of current inputs against registered history.
    always_comb begin
        viol_code_s = 3'd0;
        if ((ns_s != LT_RED) && (ew_s != LT_RED)) begin
            viol_code_s = 3'd1;
        end else if (!enc_ok(ns_s) || !enc_ok(ew_s)) begin
            viol_code_s = 3'd2;
        end else if (!seq_ok(ns_prev_q, ns_s) || !seq_ok(ew_prev_q, ew_s)) begin
            viol_code_s = 3'd3;
        end else if (((ns_s == LT_GRN) && (ns_gcnt_q == MAX_GREEN_C)) ||
                     ((ew_s == LT_GRN) && (ew_gcnt_q == MAX_GREEN_C))) begin
            viol_code_s = 3'd4;
        end else if (((ns_prev_q == LT_YEL) && (ns_s == LT_RED) && (ns_ycnt_q < MIN_YELLOW_C)) ||
                     ((ew_prev_q == LT_YEL) && (ew_s == LT_RED) && (ew_ycnt_q < MIN_YELLOW_C))) begin
            viol_code_s = 3'd5;
        end else if (((ns_s == LT_YEL) && (ns_ycnt_q == MAX_YELLOW_C)) ||
                     ((ew_s == LT_YEL) && (ew_ycnt_q == MAX_YELLOW_C))) begin
            viol_code_s = 3'd6;
        end else begin
            viol_code_s = 3'd0;
        end
    end

    // Next-state and next-output logic for the MONITOR/FAULT machine.
    always_comb begin
        state_d     = state_q;
        ns_prev_d   = ns_prev_q;
        ew_prev_d   = ew_prev_q;
        ns_gcnt_d   = ns_gcnt_q;
        ns_ycnt_d   = ns_ycnt_q;
        ew_gcnt_d   = ew_gcnt_q;
        ew_ycnt_d   = ew_ycnt_q;
        flash_cnt_d = flash_cnt_q;
        flash_red_d = flash_red_q;
        ns_lamp_d   = ns_lamp_q;
        ew_lamp_d   = ew_lamp_q;
        fault_d     = fault_q;
        code_d      = code_q;
        case (state_q)
            ST_MONITOR: begin
                if (viol_code_s != 3'd0) begin
                    // Faulted input never reaches the lamps.
                    state_d     = ST_FAULT;
                    fault_d     = 1'b1;
                    code_d      = viol_code_s;
                    ns_lamp_d   = LT_RED;
                    ew_lamp_d   = LT_RED;
                    flash_cnt_d = CNT_ZERO_C;
                    flash_red_d = 1'b1;
                end else begin
                    ns_lamp_d = ns_s;
                    ew_lamp_d = ew_s;
                    ns_prev_d = ns_s;
                    ew_prev_d = ew_s;
                    ns_gcnt_d = run_next(ns_s == LT_GRN, ns_gcnt_q);
                    ns_ycnt_d = run_next(ns_s == LT_YEL, ns_ycnt_q);
                    ew_gcnt_d = run_next(ew_s == LT_GRN, ew_gcnt_q);
                    ew_ycnt_d = run_next(ew_s == LT_YEL, ew_ycnt_q);
                end
            end
            ST_FAULT: begin
                if (bus.fault_clear && (ns_s == LT_RED) && (ew_s == LT_RED)) begin
                    state_d     = ST_MONITOR;
                    fault_d     = 1'b0;
                    code_d      = 3'd0;
                    ns_lamp_d   = LT_RED;
                    ew_lamp_d   = LT_RED;
                    ns_prev_d   = LT_RED;
                    ew_prev_d   = LT_RED;
                    ns_gcnt_d   = CNT_ZERO_C;
                    ns_ycnt_d   = CNT_ZERO_C;
                    ew_gcnt_d   = CNT_ZERO_C;
                    ew_ycnt_d   = CNT_ZERO_C;
                    flash_cnt_d = CNT_ZERO_C;
                    flash_red_d = 1'b1;
                end else begin
                    if (flash_cnt_q == FLASH_END_C) begin
                        flash_cnt_d = CNT_ZERO_C;
                        flash_red_d = ~flash_red_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + CNT_ONE_C;
                        flash_red_d = flash_red_q;
                    end
                    ns_lamp_d = flash_red_d ? LT_RED : LT_OFF;
                    ew_lamp_d = flash_red_d ? LT_RED : LT_OFF;
                end
            end
            default: begin
                // Unreachable encoding: fail safe into FAULT with red lamps.
                state_d     = ST_FAULT;
                fault_d     = 1'b1;
                ns_lamp_d   = LT_RED;
                ew_lamp_d   = LT_RED;
                flash_cnt_d = CNT_ZERO_C;
                flash_red_d = 1'b1;
            end
        endcase
    end

    // State, history, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_MONITOR;
            ns_prev_q   <= LT_RED;
            ew_prev_q   <= LT_RED;
            ns_gcnt_q   <= CNT_ZERO_C;
            ns_ycnt_q   <= CNT_ZERO_C;
            ew_gcnt_q   <= CNT_ZERO_C;
            ew_ycnt_q   <= CNT_ZERO_C;
            flash_cnt_q <= CNT_ZERO_C;
            flash_red_q <= 1'b1;
            ns_lamp_q   <= LT_RED;
            ew_lamp_q   <= LT_RED;
            fault_q     <= 1'b0;
            code_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            ns_prev_q   <= ns_prev_d;
            ew_prev_q   <= ew_prev_d;
            ns_gcnt_q   <= ns_gcnt_d;
            ns_ycnt_q   <= ns_ycnt_d;
            ew_gcnt_q   <= ew_gcnt_d;
            ew_ycnt_q   <= ew_ycnt_d;
            flash_cnt_q <= flash_cnt_d;
            flash_red_q <= flash_red_d;
            ns_lamp_q   <= ns_lamp_d;
            ew_lamp_q   <= ew_lamp_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign bus.ns_lamp    = ns_lamp_q;
    assign bus.ew_lamp    = ew_lamp_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
endmodule
